fifo_rd_sched: RTL and testbench

Read-side burst scheduler for the asynchronous FIFO: shares the single FIFO read port among NUM_REQ consumers in the read clock domain. Grants one consumer at a time with round-robin fairness, drives the read-pointer block's rd_en, and tags each returned data beat with its owner. It sits between the consumers and the read pointer / FIFO memory, and observes the registered empty flag.

---
 rtl/fifo_rd_sched_pkg.sv | 24 ++
 rtl/fifo_rd_sched_if.sv | 27 ++
 rtl/fifo_rd_sched_rr_pick.sv | 50 +++++
 rtl/fifo_rd_sched.sv | 126 ++++++++++++
 tb/tb_fifo_rd_sched.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/fifo_rd_sched_pkg.sv
// Shared types and width helpers for the FIFO control blocks.
//   rd_sched_state_t : read scheduler FSM states
//   cnt_width()      : bits needed to count 0..max_val inclusive
//   idx_width()      : bits needed to index n items (at least 1)
package fifo_ctrl_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_sched_state_t;

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_BURST_LEN = 8;
    localparam int DEF_MAX_WAIT  = 16;

endpackage

// File: rtl/fifo_rd_sched_if.sv
// Read-side scheduler bundle between consumers / read pointer block and
// the scheduler.
//   master : scheduler view (drives rd_en, gnt, vld, last, busy)
//   slave  : consumer / FIFO view (drives req, empty)
interface fifo_rd_sched_if
    import fifo_ctrl_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ
);
    logic [NUM_REQ-1:0] req;
    logic               empty;
    logic               rd_en;
    logic [NUM_REQ-1:0] gnt;
    logic [NUM_REQ-1:0] vld;
    logic               last;
    logic               busy;

    modport master (
        input  req, empty,
        output rd_en, gnt, vld, last, busy
    );

    modport slave (
        output req, empty,
        input  rd_en, gnt, vld, last, busy
    );
endinterface

// File: rtl/fifo_rd_sched_rr_pick.sv
// Combinational round-robin selector: the first set req bit at or after
// ptr (wrapping) wins.
//   req     : request vector
//   ptr     : index with highest priority
//   win_oh  : one-hot winner (0 when no request)
//   win_idx : index of the winner
//   req_any : at least one request present
module rr_pick
    import fifo_ctrl_pkg::*;
#(
    parameter  int N  = DEF_NUM_REQ,
    localparam int IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win_oh,
    output logic [IW-1:0] win_idx,
    output logic          req_any
);

    // One extra bit so ptr + i cannot overflow before the wrap subtraction.
    logic [IW:0] cand_s;
    logic        found_s;

    // Scan candidates in priority order starting at ptr.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        found_s = 1'b0;
        cand_s  = '0;
        req_any = |req;
        for (int i = 0; i < N; i++) begin
            cand_s = {1'b0, ptr} + (IW+1)'(i);
            if (cand_s >= (IW+1)'(N)) begin
                cand_s = cand_s - (IW+1)'(N);
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && req[cand_s[IW-1:0]]) begin
                found_s                 = 1'b1;
                win_idx                 = cand_s[IW-1:0];
                win_oh                  = '0;
                win_oh[cand_s[IW-1:0]]  = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/fifo_rd_sched.sv
// Read-side burst scheduler: shares the single FIFO read port among
// NUM_REQ consumers with round-robin fairness, drives rd_en and tags each
// returned beat with its owner.
//   rd_clk  : read-domain clock
//   rd_rstn : synchronous active-low reset
//   bus     : master modport (req/empty in; rd_en/gnt/vld/last/busy out)
module fifo_rd_sched
    import fifo_ctrl_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int MAX_WAIT  = DEF_MAX_WAIT
) (
    input  logic             rd_clk,
    input  logic             rd_rstn,
    fifo_rd_sched_if.master  bus
);

    localparam int IW = idx_width(NUM_REQ);
    localparam int BW = cnt_width(BURST_LEN);
    localparam int WW = cnt_width(MAX_WAIT);

    localparam logic [BW-1:0] BEAT_LAST = BW'(BURST_LEN - 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);
    localparam logic [IW-1:0] PTR_MAX   = IW'(NUM_REQ - 1);

    rd_sched_state_t    state_r;
    logic [NUM_REQ-1:0] gnt_r;
    logic [NUM_REQ-1:0] vld_r;
    logic               last_r;
    logic               busy_r;
    logic [IW-1:0]      ptr_r;
    logic [BW-1:0]      beat_cnt_r;
    logic [WW-1:0]      wait_cnt_r;

    logic [NUM_REQ-1:0] win_oh_s;
    logic [IW-1:0]      win_idx_s;
    logic [IW-1:0]      ptr_next_s;
    logic               req_any_s;
    logic               owner_req_s;
    logic               rd_en_s;
    logic               beat_done_s;
    logic               starve_s;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req     (bus.req),
        .ptr     (ptr_r),
        .win_oh  (win_oh_s),
        .win_idx (win_idx_s),
        .req_any (req_any_s)
    );

    // gnt_r is zero in IDLE, so owner_req_s also gates reads out of IDLE.
    assign owner_req_s = |(bus.req & gnt_r);
    assign rd_en_s     = (state_r == BURST) & owner_req_s & ~bus.empty;
    assign beat_done_s = rd_en_s & (beat_cnt_r == BEAT_LAST);
    assign starve_s    = (state_r == BURST) & owner_req_s & bus.empty
                         & (wait_cnt_r == WAIT_LAST);
    assign ptr_next_s  = (win_idx_s == PTR_MAX) ? IW'(0) : (win_idx_s + IW'(1));

    // Scheduler FSM with counters and registered grant/beat outputs.
    always_ff @(posedge rd_clk) begin
        if (!rd_rstn) begin
            state_r    <= IDLE;
            gnt_r      <= '0;
            vld_r      <= '0;
            last_r     <= 1'b0;
            busy_r     <= 1'b0;
            ptr_r      <= '0;
            beat_cnt_r <= '0;
            wait_cnt_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    vld_r  <= '0;
                    last_r <= 1'b0;
                    if (req_any_s) begin
                        state_r    <= BURST;
                        gnt_r      <= win_oh_s;
                        busy_r     <= 1'b1;
                        ptr_r      <= ptr_next_s;
                        beat_cnt_r <= '0;
                        wait_cnt_r <= '0;
                    end else begin
                        gnt_r  <= '0;
                        busy_r <= 1'b0;
                    end
                end
                BURST: begin
                    vld_r  <= rd_en_s ? gnt_r : '0;
                    last_r <= beat_done_s;
                    if (rd_en_s) begin
                        beat_cnt_r <= beat_cnt_r + BW'(1);
                        wait_cnt_r <= '0;
                    end else if (owner_req_s) begin
                        wait_cnt_r <= wait_cnt_r + WW'(1);
                    end else begin
                        wait_cnt_r <= wait_cnt_r;
                    end
                    // Release on completion, request drop or starvation.
                    if (!owner_req_s || beat_done_s || starve_s) begin
                        state_r <= IDLE;
                        gnt_r   <= '0;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= BURST;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    gnt_r   <= '0;
                    vld_r   <= '0;
                    last_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.rd_en = rd_en_s;
    assign bus.gnt   = gnt_r;
    assign bus.vld   = vld_r;
    assign bus.last  = last_r;
    assign bus.busy  = busy_r;

endmodule

// File: tb/tb_fifo_rd_sched.sv
// Scoreboard bench for fifo_rd_sched: a driver applies directed and random
// req/empty/reset patterns and runs a transaction-level model that pushes
// each expected beat; a separate monitor pops and compares on vld.
module tb_fifo_rd_sched;

    localparam int NR = 4;
    localparam int BL = 8;
    localparam int MW = 16;

    logic rd_clk  = 1'b0;
    logic rd_rstn = 1'b0;

    fifo_rd_sched_if #(.NUM_REQ(NR)) bus ();

    fifo_rd_sched #(.NUM_REQ(NR), .BURST_LEN(BL), .MAX_WAIT(MW)) dut (
        .rd_clk  (rd_clk),
        .rd_rstn (rd_rstn),
        .bus     (bus)
    );

    always #5 rd_clk = ~rd_clk;

    int cyc = 0;
    always @(posedge rd_clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int owner;
        bit last;
    } beat_t;

    beat_t exp_q[$];
    int tests = 0;
    int fails = 0;
    bit done  = 1'b0;

    // Model: who owns the port, beats taken, stalled cycles, next priority.
    int m_owner = -1;
    int m_beats = 0;
    int m_waits = 0;
    int m_ptr   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, req);
        end
    endtask

    // One cycle: check registered state, drive inputs, check rd_en, advance model.
    task automatic step(input logic [NR-1:0] r, input logic e, input logic rst, output bit rd);
        int w;
        @(negedge rd_clk);
        check("gnt", 32'(bus.gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        check("busy", 32'(bus.busy), (m_owner >= 0) ? 32'd1 : 32'd0);
        bus.req  = r;
        bus.empty = e;
        rd_rstn  = rst;
        rd = (m_owner >= 0) && r[m_owner] && !e;
        #1;
        check("rd_en", 32'(bus.rd_en), rd ? 32'd1 : 32'd0);
        if (!rst) begin
            m_owner = -1; m_beats = 0; m_waits = 0; m_ptr = 0;
        end else if (m_owner < 0) begin
            if (r != '0) begin
                w = m_ptr;
                for (int i = 0; i < NR; i++) begin
                    w = (m_ptr + i) % NR;
                    if (r[w]) break;
                end
                m_owner = w; m_beats = 0; m_waits = 0; m_ptr = (w + 1) % NR;
            end
        end else if (!r[m_owner]) begin
            m_owner = -1;
        end else if (!e) begin
            m_beats++;
            m_waits = 0;
            exp_q.push_back('{cyc: cyc, owner: m_owner, last: (m_beats == BL)});
            if (m_beats == BL) m_owner = -1;
        end else begin
            m_waits++;
            if (m_waits == MW) m_owner = -1;
        end
    endtask

    task automatic idle(input int n);
        bit rd;
        for (int i = 0; i < n; i++) step('0, 1'b1, 1'b1, rd);
    endtask

    // Monitor: every beat on vld must match the oldest expected beat.
    initial begin
        beat_t b;
        forever begin
            @(negedge rd_clk);
            if (done) break;
            if (bus.vld != '0) begin
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL spurious_vld cyc=%0d actual vld=%b required none", cyc, bus.vld);
                end else begin
                    b = exp_q.pop_front();
                    if (bus.vld !== NR'(1 << b.owner) || bus.last !== b.last || b.cyc != cyc - 1) begin
                        fails++;
                        $display("FAIL beat cyc=%0d actual vld=%b last=%b required vld=%b last=%b read_cyc=%0d",
                                 cyc, bus.vld, bus.last, NR'(1 << b.owner), b.last, b.cyc);
                    end
                end
            end else begin
                check("last_without_vld", 32'(bus.last), 32'd0);
                if (exp_q.size() > 0 && exp_q[0].cyc <= cyc - 1) begin
                    tests++;
                    fails++;
                    $display("FAIL missing_vld cyc=%0d actual vld=0 required owner=%0d", cyc, exp_q[0].owner);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        bit rd;
        int words;
        logic [NR-1:0] rq;
        bus.req   = '0;
        bus.empty = 1'b1;
        rd_rstn   = 1'b0;
        repeat (2) @(posedge rd_clk);
        @(negedge rd_clk);
        check("reset_gnt", 32'(bus.gnt), 32'd0);
        check("reset_vld", 32'(bus.vld), 32'd0);
        check("reset_last", 32'(bus.last), 32'd0);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_rd_en", 32'(bus.rd_en), 32'd0);
        idle(2);

        // Single consumer, FIFO preloaded with 20 words.
        words = 20;
        for (int k = 0; k < 40; k++) begin
            step(4'b0001, (words == 0), 1'b1, rd);
            if (rd) words--;
        end
        check("words_drained", 32'(words), 32'd0);
        idle(2);

        // All consumers requesting, FIFO never empty.
        for (int k = 0; k < 45; k++) step(4'b1111, 1'b0, 1'b1, rd);
        idle(2);

        // Owner 2 starves after 3 beats; then everyone requests (ptr must be 3).
        for (int k = 0; k < 20; k++) step(4'b0100, (k >= 4), 1'b1, rd);
        for (int k = 0; k < 10; k++) step(4'b1111, 1'b0, 1'b1, rd);
        idle(2);

        // Owner 1 drops req after beat 5 while consumer 3 waits.
        for (int k = 0; k < 6; k++) step(4'b0010, 1'b0, 1'b1, rd);
        for (int k = 0; k < 12; k++) step(4'b1000, 1'b0, 1'b1, rd);
        idle(2);

        // Reset pulse during beat 4 of a burst.
        for (int k = 0; k < 4; k++) step(4'b0001, 1'b0, 1'b1, rd);
        step(4'b0001, 1'b0, 1'b0, rd);
        for (int k = 0; k < 15; k++) step(4'b0011, 1'b0, 1'b1, rd);
        idle(2);

        // Empty toggling every cycle.
        for (int k = 0; k < 25; k++) step(4'b0001, k[0], 1'b1, rd);
        idle(2);

        // Random traffic.
        rq = '0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(7) == 0) rq = NR'($urandom);
            step(rq, ($urandom_range(2) == 0), ($urandom_range(499) != 0), rd);
        end

        idle(4);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
